scandoubler_rotate_memport: RTL and testbench

//  SDRAM-side responder for the rotating scandoubler's vidin/vidout ports; performs the cornerturn.

---
 rtl/scandoubler_rotate_memport_pkg.sv | 34 +++
 rtl/scandoubler_rotate_memport.sv | 143 ++++++++++++++
 tb/tb_scandoubler_rotate_memport.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scandoubler_rotate_memport_pkg.sv
// Shared constants and the frame-buffer address map for the rotating scandoubler's
// SDRAM-side memory port.
package scandoubler_rotate_memport_pkg;

    localparam int WR_BURST = 16;
    localparam int RD_BURST = 8;
    localparam int WCNT_W   = $clog2(WR_BURST);
    localparam int RCNT_W   = $clog2(RD_BURST);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_WAIT  = 3'd1;
    localparam logic [2:0] ST_WR_ISSUE = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_DATA  = 3'd4;

    // Word offset of pixel (row, col) in a frame: {frame, row[H-1:3], col[H-1:0], row[2:0]}.
    // Eight consecutive rows of one column land on consecutive words.
    function automatic logic [63:0] pixel_offset(input logic        frame,
                                                 input logic [31:0] row,
                                                 input logic [31:0] col,
                                                 input int          hcnt_width);
        logic [63:0] mask;
        logic [63:0] r;
        logic [63:0] c;
        mask = (64'd1 << hcnt_width) - 64'd1;
        r    = {32'd0, row} & mask;
        c    = {32'd0, col} & mask;
        return ({63'd0, frame} << (2 * hcnt_width))
             | ((r >> 3) << (hcnt_width + 3))
             | (c << 3)
             | (r & 64'd7);
    endfunction

endpackage

// File: rtl/scandoubler_rotate_memport.sv
// SDRAM-side responder for the rotating scandoubler: turns 16-word vidin write bursts into
// single-word writes and serves vidout as 8-word column read bursts (the cornerturn).
module scandoubler_rotate_memport
    import scandoubler_rotate_memport_pkg::*;
#(
    parameter int                    HCNT_WIDTH = 10,
    parameter int                    ADDR_WIDTH = 22,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,

    input  logic                  vidin_req,
    input  logic                  vidin_frame,
    input  logic [HCNT_WIDTH-1:0] vidin_row,
    input  logic [HCNT_WIDTH-1:0] vidin_col,
    input  logic [15:0]           vidin_d,
    output logic                  vidin_ack,

    input  logic                  vidout_req,
    input  logic                  vidout_frame,
    input  logic [HCNT_WIDTH-1:0] vidout_row,
    input  logic [HCNT_WIDTH-1:0] vidout_col,
    output logic [15:0]           vidout_d,
    output logic                  vidout_ack,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [15:0]           mem_rdata
);

    logic [2:0]        state;
    logic              wait_cnt;
    logic [WCNT_W-1:0] wcnt;
    logic [RCNT_W-1:0] rcnt;
    logic [RCNT_W-1:0] skip;

    logic [ADDR_WIDTH-1:0] wr_addr_next;
    logic [ADDR_WIDTH-1:0] rd_addr_next;
    logic [HCNT_WIDTH-1:0] rd_row_aligned;

    // The read side is transposed: vidout_col is the image row (Y), vidout_row the image column (X).
    assign rd_row_aligned = {vidout_col[HCNT_WIDTH-1:3], 3'b000};

    assign wr_addr_next = BASE_ADDR + ADDR_WIDTH'(pixel_offset(vidin_frame,
                                                               32'(vidin_row),
                                                               32'(vidin_col),
                                                               HCNT_WIDTH));
    assign rd_addr_next = BASE_ADDR + ADDR_WIDTH'(pixel_offset(vidout_frame,
                                                               32'(rd_row_aligned),
                                                               32'(vidout_row),
                                                               HCNT_WIDTH));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= 1'b0;
            wcnt       <= '0;
            rcnt       <= '0;
            skip       <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            vidin_ack  <= 1'b0;
            vidout_ack <= 1'b0;
            vidout_d   <= '0;
        end else begin
            // NOTE: ack strobes default low each cycle so they can only ever be one-cycle pulses.
            vidin_ack  <= 1'b0;
            vidout_ack <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (vidin_req) begin
                        state    <= ST_WR_WAIT;
                        wcnt     <= '0;
                        wait_cnt <= 1'b0;
                    end else if (vidout_req) begin
                        state    <= ST_RD_ISSUE;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= rd_addr_next;
                        skip     <= vidout_col[2:0];
                        rcnt     <= '0;
                    end
                end

                // The source needs two cycles after each ack to present the next word.
                ST_WR_WAIT: begin
                    if (wait_cnt) begin
                        wait_cnt  <= 1'b0;
                        state     <= ST_WR_ISSUE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr_next;
                        mem_wdata <= vidin_d;
                    end else begin
                        wait_cnt <= 1'b1;
                    end
                end

                ST_WR_ISSUE: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        vidin_ack <= 1'b1;
                        wcnt      <= wcnt + 1'b1;
                        state     <= (wcnt == WCNT_W'(WR_BURST - 1)) ? ST_IDLE : ST_WR_WAIT;
                    end
                end

                ST_RD_ISSUE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_RD_DATA;
                    end
                end

                // Every word of the burst is drained; only those at or after the requested Y
                // and while the consumer still wants them are acknowledged.
                ST_RD_DATA: begin
                    if (mem_rvalid) begin
                        vidout_d   <= mem_rdata;
                        vidout_ack <= vidout_req && (rcnt >= skip);
                        rcnt       <= rcnt + 1'b1;
                        if (rcnt == RCNT_W'(RD_BURST - 1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scandoubler_rotate_memport.sv
// Self-checking bench: table-driven plus randomized bursts against an SDRAM model and a
// pixel-coordinate address reference, with hand-written reset and arbitration sequences.
module tb_scandoubler_rotate_memport;

    localparam int H = 10;
    localparam int A = 22;
    localparam logic [A-1:0] BASE = 22'h200000;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          vidin_req, vidin_frame;
    logic [H-1:0]  vidin_row, vidin_col;
    logic [15:0]   vidin_d;
    logic          vidin_ack;
    logic          vidout_req, vidout_frame;
    logic [H-1:0]  vidout_row, vidout_col;
    logic [15:0]   vidout_d;
    logic          vidout_ack;
    logic          mem_req, mem_we;
    logic [A-1:0]  mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_ack, mem_rvalid;
    logic [15:0]   mem_rdata;

    scandoubler_rotate_memport #(.HCNT_WIDTH(H), .ADDR_WIDTH(A), .BASE_ADDR(BASE)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .vidin_req(vidin_req), .vidin_frame(vidin_frame), .vidin_row(vidin_row),
        .vidin_col(vidin_col), .vidin_d(vidin_d), .vidin_ack(vidin_ack),
        .vidout_req(vidout_req), .vidout_frame(vidout_frame), .vidout_row(vidout_row),
        .vidout_col(vidout_col), .vidout_d(vidout_d), .vidout_ack(vidout_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference address map in pixel coordinates: frame, image row y, image column x.
    function automatic int addr_of(input bit frame, input int y, input int x);
        return int'(BASE) + int'(frame) * (1 << (2 * H)) + (y / 8) * (1 << (H + 3)) + x * 8 + (y % 8);
    endfunction

    // SDRAM contents; unwritten words read back as an address-derived pattern.
    logic [15:0] sdram [int];
    function automatic logic [15:0] sdram_rd(input int a);
        return sdram.exists(a) ? sdram[a] : (16'(a) ^ 16'h5a5a);
    endfunction

    typedef struct { int addr; logic [15:0] data; } wr_t;
    wr_t wr_log[$];

    int rd_left = 0, rd_base = 0, rd_idx = 0, gap = 0, ack_delay = 0;
    int last_rd_addr = -1, rd_issue_count = 0, rv_count = 0;
    bit acked_last = 0;
    logic prev_req = 0, prev_we = 0;
    logic [A-1:0] prev_addr = '0;
    logic [15:0] prev_wdata = '0;

    // SDRAM controller model with protocol monitor.
    initial begin
        mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;
        forever begin
            @(negedge clk_sys);
            mem_ack = 0;
            mem_rvalid = 0;
            if (!reset_n) begin
                rd_left = 0; prev_req = 0; acked_last = 0;
            end else begin
                if (prev_req && !acked_last) begin
                    check("mem_req_held_until_ack", mem_req, 1);
                    if (mem_req)
                        check("mem_cmd_stable", {mem_we, mem_addr, mem_wdata},
                              {prev_we, prev_addr, prev_wdata});
                end
                acked_last = 0;
                if (mem_req && rd_left > 0)
                    check("no_req_during_read_burst", mem_req, 0);
                if (mem_req && rd_left == 0) begin
                    if (ack_delay == 0) begin
                        mem_ack = 1;
                        acked_last = 1;
                        ack_delay = $urandom_range(0, 3);
                        if (mem_we) begin
                            sdram[int'(mem_addr)] = mem_wdata;
                            wr_log.push_back('{int'(mem_addr), mem_wdata});
                        end else begin
                            rd_base = int'(mem_addr); rd_idx = 0; rd_left = 8;
                            gap = $urandom_range(0, 2);
                            last_rd_addr = rd_base; rd_issue_count++; rv_count = 0;
                        end
                    end else begin
                        ack_delay--;
                    end
                end else if (rd_left > 0) begin
                    if (gap == 0) begin
                        mem_rvalid = 1;
                        mem_rdata = sdram_rd(rd_base + rd_idx);
                        rd_idx++; rd_left--; rv_count++;
                        gap = $urandom_range(0, 2);
                    end else begin
                        gap--;
                    end
                end
            end
            prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr; prev_wdata = mem_wdata;
        end
    end

    int wr_ack_cycle = 0;
    int first_rd_ack_cycle = 0;

    task automatic do_write(input bit frame, input int row, input int col0, input logic [15:0] d0,
                            input int exp_addr);
        int k, last, budget, start_log;
        start_log = wr_log.size();
        vidin_frame = frame; vidin_row = H'(row); vidin_col = H'(col0); vidin_d = d0;
        vidin_req = 1;
        k = 0; last = 0; budget = 0;
        while (k < 16 && budget < 3000) begin
            @(negedge clk_sys);
            budget++;
            if (vidin_ack) begin
                if (k > 0) check("wr_ack_spacing_ge3", (cyc - last) >= 3, 1);
                last = cyc; k++; wr_ack_cycle = cyc;
                if (k == 16) vidin_req = 0;
                else begin
                    vidin_col = H'(col0 + k);
                    vidin_d = d0 + 16'(k);
                end
            end
        end
        vidin_req = 0;
        check("wr_ack_count", k, 16);
        check("wr_mem_writes", wr_log.size() - start_log, 16);
        if (wr_log.size() > start_log) check("wr_first_addr", wr_log[start_log].addr, exp_addr);
        for (int i = 0; i < 16 && start_log + i < wr_log.size(); i++) begin
            check("wr_addr", wr_log[start_log + i].addr, addr_of(frame, row, col0 + i));
            check("wr_data", wr_log[start_log + i].data, d0 + 16'(i));
        end
    endtask

    task automatic do_read(input bit frame, input int x, input int y, input int exp_acks,
                           input int exp_addr);
        logic [15:0] exp_q[$];
        int got, budget, ybase;
        ybase = y - (y % 8);
        for (int k = y % 8; k < 8; k++) exp_q.push_back(sdram_rd(addr_of(frame, ybase + k, x)));
        vidout_frame = frame; vidout_row = H'(x); vidout_col = H'(y);
        vidout_req = 1;
        got = 0; budget = 0;
        while (vidout_req && budget < 3000) begin
            @(negedge clk_sys);
            budget++;
            if (vidout_ack) begin
                if (got < exp_q.size()) check("rd_data", vidout_d, exp_q[got]);
                if (got == 0) first_rd_ack_cycle = cyc;
                got++;
                vidout_col = vidout_col + 1'b1;
                if (got >= exp_acks) vidout_req = 0;
            end
        end
        vidout_req = 0;
        repeat (30) begin
            @(negedge clk_sys);
            if (vidout_ack) got++;
        end
        check("rd_ack_count", got, exp_acks);
        check("rd_burst_addr", last_rd_addr, exp_addr);
        check("rd_burst_drained", rd_left, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_vidin_ack", vidin_ack, 0);
        check("rst_vidout_ack", vidout_ack, 0);
        check("rst_vidout_d", vidout_d, 0);
    endtask

    typedef struct {
        bit          is_write;
        bit          frame;
        int          row;       // write: image row; read: vidout_row (image column X)
        int          col;       // write: image column; read: vidout_col (image row Y)
        logic [15:0] d0;
        int          exp_acks;
        int          exp_addr;  // write: first word address; read: burst start address
    } vec_t;

    vec_t vecs[$];

    initial begin
        int avail, drop, issue0, budget;
        vec_t v;

        reset_n = 0;
        vidin_req = 0; vidin_frame = 0; vidin_row = 0; vidin_col = 0; vidin_d = 0;
        vidout_req = 0; vidout_frame = 0; vidout_row = 0; vidout_col = 0;
        repeat (3) @(negedge clk_sys);
        check_reset_outputs();
        reset_n = 1;
        repeat (2) @(negedge clk_sys);

        for (int k = 0; k < 8; k++) sdram[addr_of(0, k, 'h40)] = 16'h00A0 + 16'(k);

        vecs.push_back('{1'b1, 1'b1, 5,     'h20, 16'h1000, 16, 'h300105});
        vecs.push_back('{1'b0, 1'b0, 'h40,  0,    16'h0,    8,  'h200200});
        vecs.push_back('{1'b0, 1'b0, 'h41,  'h0B, 16'h0,    5,  'h202208});
        // drop after 5 acks: modelled by asking for only 5 from a full 8-word burst
        vecs.push_back('{1'b0, 1'b1, 'h123, 'h10, 16'h0,    5,  'h304918});
        for (int i = 0; i < 14; i++) begin
            v.is_write = 1'($urandom_range(0, 1));
            v.frame = 1'($urandom_range(0, 1));
            if (v.is_write) begin
                v.row = $urandom_range(0, 1023);
                v.col = $urandom_range(0, 1008);
                v.d0 = 16'($urandom);
                v.exp_acks = 16;
                v.exp_addr = addr_of(v.frame, v.row, v.col);
            end else begin
                v.row = $urandom_range(0, 1023);
                v.col = $urandom_range(0, 1023);
                v.d0 = 0;
                avail = 8 - (v.col % 8);
                drop = ($urandom_range(0, 2) == 0 && avail > 1) ? $urandom_range(1, avail - 1) : -1;
                v.exp_acks = (drop >= 0) ? drop : avail;
                v.exp_addr = addr_of(v.frame, v.col - (v.col % 8), v.row);
            end
            vecs.push_back(v);
        end

        foreach (vecs[i]) begin
            if (vecs[i].is_write)
                do_write(vecs[i].frame, vecs[i].row, vecs[i].col, vecs[i].d0, vecs[i].exp_addr);
            else
                do_read(vecs[i].frame, vecs[i].row, vecs[i].col, vecs[i].exp_acks, vecs[i].exp_addr);
            repeat (2) @(negedge clk_sys);
        end

        // Simultaneous requests: the whole write burst must complete before any read ack.
        fork
            do_write(1'b1, 'h200, 'h100, 16'h7700, addr_of(1, 'h200, 'h100));
            do_read(1'b0, 'h300, 'h18, 8, addr_of(0, 'h18, 'h300));
        join
        check("write_before_read", first_rd_ack_cycle > wr_ack_cycle, 1);
        repeat (2) @(negedge clk_sys);

        // Reset in the middle of a read burst after 3 words have arrived.
        vidout_frame = 0; vidout_row = H'('h55); vidout_col = 0;
        issue0 = rd_issue_count;
        vidout_req = 1;
        budget = 0;
        while (!(rd_issue_count > issue0 && rv_count >= 3) && budget < 500) begin
            @(negedge clk_sys);
            budget++;
        end
        check("rst_mid_burst_3_rvalids", rd_issue_count > issue0 && rv_count >= 3, 1);
        @(posedge clk_sys);
        #1 reset_n = 0;
        #1 check_reset_outputs();
        vidout_req = 0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1;
        repeat (2) @(negedge clk_sys);
        do_read(1'b0, 'h55, 0, 8, addr_of(0, 0, 'h55));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
